// File: rtl/tanh_core_arbiter.sv
// rtl/tanh_core_arbiter.sv - round-robin sharing of one tanh LUT core between p-bit requesters
//
// Optional feature macro: TANH_ARB_REQ_MASK_EN (adds req_mask input; masked requesters are skipped)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   req         per-requester request level
//   req_mask    per-requester mask (only with TANH_ARB_REQ_MASK_EN)
//   req_phase   packed phases, requester i at [i*PHASE_W +: PHASE_W]
//   ack         one-cycle one-hot pulse: phase captured
//   core_phase  registered phase driven to the tanh core, held for the whole lookup
//   core_tanh   tanh core output
//   rsp_valid   one-cycle result strobe
//   rsp_id      requester that owns the result
//   rsp_tanh    captured tanh value
//   busy        lookup in flight
module tanh_core_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int PHASE_W  = 8,
    parameter int TANH_W   = 8,
    parameter int CORE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
`ifdef TANH_ARB_REQ_MASK_EN
    input  logic [N_REQ-1:0]           req_mask,
`endif
    input  logic [N_REQ*PHASE_W-1:0]   req_phase,
    output logic [N_REQ-1:0]           ack,
    output logic [PHASE_W-1:0]         core_phase,
    input  logic [TANH_W-1:0]          core_tanh,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [TANH_W-1:0]          rsp_tanh,
    output logic                       busy
);

    localparam int CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {IDLE, HOLD, CAPTURE} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr, rr_d;
    logic [CNT_W-1:0]       hold_cnt, cnt_d;
    logic [ID_W-1:0]        gnt_id, gnt_d;
    logic [PHASE_W-1:0]     phase_d;
    logic [N_REQ-1:0]       ack_d;
    logic                   vld_d;
    logic [ID_W-1:0]        rid_d;
    logic [TANH_W-1:0]      rt_d;
    logic                   busy_d;

    logic [N_REQ-1:0]       eff_req;
    logic                   pick_any;
    logic [ID_W-1:0]        pick_id;
    logic                   do_grant;

`ifdef TANH_ARB_REQ_MASK_EN
    assign eff_req = req & ~req_mask;
`else
    assign eff_req = req;
`endif

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // Walk offsets from the highest down so the last hit is the one closest
    // to rr_ptr; avoids a loop break while keeping first-from-pointer priority.
    always_comb begin
        pick_any = 1'b0;
        pick_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eff_req[wrap_add(rr_ptr, i)]) begin
                pick_any = 1'b1;
                pick_id  = wrap_add(rr_ptr, i);
            end
        end
    end

    // Only IDLE and CAPTURE look at requests; HOLD keeps them waiting.
    assign do_grant = pick_any && (state_q == IDLE || state_q == CAPTURE);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_ptr;
        cnt_d   = hold_cnt;
        gnt_d   = gnt_id;
        phase_d = core_phase;
        ack_d   = '0;
        vld_d   = 1'b0;
        rid_d   = rsp_id;
        rt_d    = rsp_tanh;
        busy_d  = busy;
        case (state_q)
            IDLE: begin
            end
            HOLD: begin
                cnt_d = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) state_d = CAPTURE;
            end
            CAPTURE: begin
                vld_d   = 1'b1;
                rt_d    = core_tanh;
                rid_d   = gnt_id;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (do_grant) begin
            gnt_d          = pick_id;
            phase_d        = req_phase[int'(pick_id) * PHASE_W +: PHASE_W];
            ack_d[pick_id] = 1'b1;
            rr_d           = (int'(pick_id) == N_REQ - 1) ? '0 : pick_id + 1'b1;
            cnt_d          = '0;
            busy_d         = 1'b1;
            state_d        = HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            gnt_id     <= '0;
            core_phase <= '0;
            ack        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_tanh   <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr     <= rr_d;
            hold_cnt   <= cnt_d;
            gnt_id     <= gnt_d;
            core_phase <= phase_d;
            ack        <= ack_d;
            rsp_valid  <= vld_d;
            rsp_id     <= rid_d;
            rsp_tanh   <= rt_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_tanh_core_arbiter.sv
// tb/tb_tanh_core_arbiter.sv - directed self-checking bench for tanh_core_arbiter
module tb_tanh_core_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
`ifdef TANH_ARB_REQ_MASK_EN
    logic [3:0]  req_mask = '0;
`endif
    logic [31:0] req_phase = '0;
    logic [3:0]  ack;
    logic [7:0]  core_phase;
    logic [7:0]  core_tanh;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_tanh;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    tanh_core_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
`ifdef TANH_ARB_REQ_MASK_EN
        .req_mask   (req_mask),
`endif
        .req_phase  (req_phase),
        .ack        (ack),
        .core_phase (core_phase),
        .core_tanh  (core_tanh),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_tanh   (rsp_tanh),
        .busy       (busy)
    );

    // Reference tanh core: magnitude = min(2*|phase|, 127) through a
    // 3-register pipeline, sign taken combinationally from the current phase.
    function automatic logic [7:0] lut_mag(input logic [7:0] ph);
        int a;
        a = int'($signed(ph));
        if (a < 0) a = -a;
        a = a * 2;
        if (a > 127) a = 127;
        return 8'(a);
    endfunction

    logic [7:0] p1, p2, p3;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= '0; p2 <= '0; p3 <= '0;
        end else begin
            p1 <= lut_mag(core_phase);
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign core_tanh = core_phase[7] ? 8'(-p3) : p3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_core_phase", 32'(core_phase), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_tanh", 32'(rsp_tanh), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // single request from requester 2, phase E0 -> tanh C0
        req = 4'b0100;
        req_phase = 32'h00E0_0000;
        tick();
        check("single_ack", 32'(ack), 32'h4);
        check("single_busy", 32'(busy), 32'h1);
        check("single_phase0", 32'(core_phase), 32'hE0);
        req = 4'b0000;
        tick();
        check("single_ack_pulse", 32'(ack), 32'h0);
        check("single_phase1", 32'(core_phase), 32'hE0);
        tick();
        check("single_phase2", 32'(core_phase), 32'hE0);
        check("single_novalid2", 32'(rsp_valid), 32'h0);
        tick();
        check("single_phase3", 32'(core_phase), 32'hE0);
        check("single_novalid3", 32'(rsp_valid), 32'h0);
        tick();
        check("single_valid", 32'(rsp_valid), 32'h1);
        check("single_id", 32'(rsp_id), 32'h2);
        check("single_tanh", 32'(rsp_tanh), 32'hC0);
        check("single_idle", 32'(busy), 32'h0);
        check("single_phase_kept", 32'(core_phase), 32'hE0);
        tick();
        check("single_valid_pulse", 32'(rsp_valid), 32'h0);

        // fairness: all four held high for 16 lookups
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_phase = 32'h2018_1008;
        req = 4'b1111;
        tick();
        for (int k = 0; k < 16; k++) begin
            check("rr_ack", 32'(ack), 32'(1 << (k % 4)));
            check("rr_phase", 32'(core_phase), 32'(8 * (k % 4 + 1)));
            if (k == 15) req = 4'b0000;
            tick();
            check("rr_busy", 32'(busy), 32'h1);
            check("rr_novalid", 32'(rsp_valid), 32'h0);
            tick();
            tick();
            tick();
            check("rr_valid", 32'(rsp_valid), 32'h1);
            check("rr_id", 32'(rsp_id), 32'(k % 4));
            check("rr_tanh", 32'(rsp_tanh), 32'(16 * (k % 4 + 1)));
        end
        check("rr_end_idle", 32'(busy), 32'h0);

        // back-to-back: req0 drops at ack, req3 stays high
        req_phase = 32'h2000_0010;
        req = 4'b1001;
        tick();
        check("b2b_ack0", 32'(ack), 32'h1);
        req = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b2b_busy_a", 32'(busy), 32'h1);
        end
        tick();
        check("b2b_valid0", 32'(rsp_valid), 32'h1);
        check("b2b_id0", 32'(rsp_id), 32'h0);
        check("b2b_ack3", 32'(ack), 32'h8);
        check("b2b_busy_cap", 32'(busy), 32'h1);
        check("b2b_phase3", 32'(core_phase), 32'h20);
        req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b2b_busy_b", 32'(busy), 32'h1);
            check("b2b_novalid", 32'(rsp_valid), 32'h0);
        end
        tick();
        check("b2b_valid3", 32'(rsp_valid), 32'h1);
        check("b2b_id3", 32'(rsp_id), 32'h3);
        check("b2b_tanh3", 32'(rsp_tanh), 32'h40);
        check("b2b_idle", 32'(busy), 32'h0);

        // hold check: requester 0 changes its phase right after ack
        req_phase = 32'h0000_0010;
        req = 4'b0001;
        tick();
        check("hold_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        req_phase = 32'h0000_0090;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_phase", 32'(core_phase), 32'h10);
        end
        tick();
        check("hold_valid", 32'(rsp_valid), 32'h1);
        check("hold_tanh", 32'(rsp_tanh), 32'h20);

        // async reset in HOLD with hold_cnt == 1
        req_phase = 32'h0000_3000;
        req = 4'b0010;
        tick();
        check("rsthold_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("rsthold_phase", 32'(core_phase), 32'h0);
        check("rsthold_busy", 32'(busy), 32'h0);
        check("rsthold_ack0", 32'(ack), 32'h0);
        check("rsthold_valid", 32'(rsp_valid), 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rsthold_novalid", 32'(rsp_valid), 32'h0);
            check("rsthold_noack", 32'(ack), 32'h0);
        end
        req_phase = 32'h2018_1008;
        req = 4'b1111;
        tick();
        check("rsthold_regrant0", 32'(ack), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        check("rsthold_done", 32'(rsp_valid), 32'h1);

`ifdef TANH_ARB_REQ_MASK_EN
        // masked requesters 0 and 2 are skipped
        req_mask = 4'b0101;
        req = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("mask_ack", 32'(ack), (k % 2 == 0) ? 32'h2 : 32'h8);
            if (k == 3) req = 4'b0000;
            tick();
            tick();
            tick();
            tick();
            check("mask_id", 32'(rsp_id), (k % 2 == 0) ? 32'h1 : 32'h3);
        end
        req_mask = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
